// File: rtl/switch_debouncer_pkg.sv
// ============================================================================
// Module      : switch_pkg
// Description : Shared constants for the switch debouncer slice. It holds the
//               default switch count and the reserved sw_code values.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package switch_pkg;

    localparam int NUM_SW_DEFAULT = 4;

    // Reserved sw_code values. Codes 1..NUM_SW name the single active switch.
    localparam logic [2:0] CODE_NONE  = 3'd0;
    localparam logic [2:0] CODE_MULTI = 3'd7;

endpackage

`default_nettype wire

// File: rtl/switch_debouncer_if.sv
// ============================================================================
// Module      : switch_debouncer_if
// Description : Pin-side and conditioned-side signals of the switch debouncer.
//               master : the board/bench side. It drives the raw pins and
//                        consumes the clean outputs.
//               slave  : the debouncer itself.
//               Signals: key_raw (active-low button), sw_raw[NUM_SW],
//                        sw_clean[NUM_SW], step, multi, sw_code[3].
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface switch_debouncer_if #(
    parameter int NUM_SW = 4
) ();

    logic              key_raw;
    logic [NUM_SW-1:0] sw_raw;
    logic [NUM_SW-1:0] sw_clean;
    logic              step;
    logic              multi;
    logic [2:0]        sw_code;

    modport master (
        output key_raw,
        output sw_raw,
        input  sw_clean,
        input  step,
        input  multi,
        input  sw_code
    );

    modport slave (
        input  key_raw,
        input  sw_raw,
        output sw_clean,
        output step,
        output multi,
        output sw_code
    );

endinterface

`default_nettype wire

// File: rtl/switch_debouncer_debounce_bit.sv
// ============================================================================
// Module      : debounce_bit
// Description : One debounce channel. It contains a 2-FF synchroniser, a
//               consecutive-difference counter and the stable level register.
//               The stable value follows the synchronised input only after
//               the input has differed from it on DEBOUNCE_CYCLES consecutive
//               edges. Any return to the stable value restarts the count.
//               Ports: clk, reset (sync, active-high), d_raw (async input),
//                      d_stable (debounced level).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_bit #(
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic IDLE            = 1'b0
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic d_raw,
    output logic      d_stable
);

    localparam int c_cnt_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic               r_s1;
    logic               r_s2;
    logic               r_stable;
    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1     <= IDLE;
            r_s2     <= IDLE;
            r_stable <= IDLE;
            r_cnt    <= '0;
        end else begin
            r_s1 <= d_raw;
            r_s2 <= r_s1;
            if (r_s2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                // The input has differed on DEBOUNCE_CYCLES edges, counting this one.
                r_stable <= r_s2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end
    end

    assign d_stable = r_stable;

endmodule

`default_nettype wire

// File: rtl/switch_debouncer.sv
// ============================================================================
// Module      : switch_debouncer
// Description : Input conditioning for the switch-driven FSM. It debounces the
//               step pushbutton and NUM_SW slide switches. It then produces
//               clean switch levels, a one-cycle step pulse per press, a
//               "more than one switch on" flag and a compact switch code.
//               Ports: clk, reset (sync, active-high),
//                      bus (switch_debouncer_if.slave): key_raw, sw_raw in;
//                      sw_clean, step, multi, sw_code out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module switch_debouncer
    import switch_pkg::*;
#(
    parameter int NUM_SW          = NUM_SW_DEFAULT,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  wire logic         clk,
    input  wire logic         reset,
    switch_debouncer_if.slave bus
);

    logic              w_key_stable;
    logic              r_key_prev;
    logic [NUM_SW-1:0] w_sw_stable;
    logic              w_seen;
    logic              w_multi;
    logic [2:0]        w_index_code;
    logic [2:0]        w_code;

    // The key pin is active-low. The channel works on the inverted pin, so
    // 1 means pressed and the idle level stays 0 like the switches.
    debounce_bit #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .IDLE            (1'b0)
    ) u_key (
        .clk      (clk),
        .reset    (reset),
        .d_raw    (~bus.key_raw),
        .d_stable (w_key_stable)
    );

    generate
        for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_sw
            debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .IDLE            (1'b0)
            ) u_sw (
                .clk      (clk),
                .reset    (reset),
                .d_raw    (bus.sw_raw[gi]),
                .d_stable (w_sw_stable[gi])
            );
        end
    endgenerate

    // Rising-edge detect on the debounced key. The prev register clears to
    // "released", so a key held through reset counts as a new press.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_key_prev <= 1'b0;
        end else begin
            r_key_prev <= w_key_stable;
        end
    end

    // A second set bit implies popcount >= 2. The last set bit seen gives the
    // single-switch code.
    always_comb begin
        w_seen       = 1'b0;
        w_multi      = 1'b0;
        w_index_code = CODE_NONE;
        for (int i = 0; i < NUM_SW; i++) begin
            if (w_sw_stable[i]) begin
                if (w_seen) begin
                    w_multi = 1'b1;
                end
                w_seen       = 1'b1;
                w_index_code = 3'(i + 1);
            end
        end
    end

    always_comb begin
        w_code = CODE_NONE;
        if (w_multi) begin
            w_code = CODE_MULTI;
        end else if (w_seen) begin
            w_code = w_index_code;
        end
    end

    assign bus.sw_clean = w_sw_stable;
    assign bus.step     = w_key_stable & ~r_key_prev;
    assign bus.multi    = w_multi;
    assign bus.sw_code  = w_code;

endmodule

`default_nettype wire

// File: tb/tb_switch_debouncer.sv
// ============================================================================
// Module      : tb_switch_debouncer
// Description : Directed self-checking bench for switch_debouncer with
//               DEBOUNCE_CYCLES = 4. Expected values are hand-derived edge
//               counts. The stable level moves at edge 5 after a change that
//               is first sampled at edge 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_switch_debouncer;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    switch_debouncer_if #(.NUM_SW(4)) sif ();

    switch_debouncer #(
        .NUM_SW          (4),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge. Outputs are sampled 1 time unit later, and
    // inputs set here are taken at the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] sw, input logic st,
                                 input logic mu, input logic [2:0] code);
        check({tag, ".sw_clean"}, {4'd0, sif.sw_clean}, {4'd0, sw});
        check({tag, ".step"},     {7'd0, sif.step},     {7'd0, st});
        check({tag, ".multi"},    {7'd0, sif.multi},    {7'd0, mu});
        check({tag, ".sw_code"},  {5'd0, sif.sw_code},  {5'd0, code});
    endtask

    initial begin
        n_pass      = 0;
        n_total     = 0;
        reset       = 1'b1;
        sif.key_raw = 1'b1;
        sif.sw_raw  = 4'b0000;

        // Reset state
        ticks(2);
        check_outputs("reset", 4'b0000, 1'b0, 1'b0, 3'd0);
        reset = 1'b0;
        tick();

        // Clean single switch: still idle after edge 4, settled after edge 5
        sif.sw_raw = 4'b0001;
        ticks(5);
        check_outputs("clean_e4", 4'b0000, 1'b0, 1'b0, 3'd0);
        tick();
        check_outputs("clean_e5", 4'b0001, 1'b0, 1'b0, 3'd1);
        sif.sw_raw = 4'b0000;
        ticks(5);
        check("clean_off_e4", {4'd0, sif.sw_clean}, 8'h01);
        tick();
        check_outputs("clean_off_e5", 4'b0000, 1'b0, 1'b0, 3'd0);
        ticks(2);

        // Bounce: 3-cycle pulse on sw_raw[2] must never reach sw_clean
        sif.sw_raw = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bounce_hi.sw_clean", {4'd0, sif.sw_clean}, 8'h00);
        end
        sif.sw_raw = 4'b0000;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("bounce_lo.sw_clean", {4'd0, sif.sw_clean}, 8'h00);
            check("bounce_lo.sw_code",  {5'd0, sif.sw_code},  8'h00);
        end

        // Button: one pulse after edge 5, none while held, none on release
        sif.key_raw = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            check($sformatf("press_e%0d.step", k), {7'd0, sif.step}, (k == 5) ? 8'h01 : 8'h00);
        end
        sif.key_raw = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            check($sformatf("release_e%0d.step", k), {7'd0, sif.step}, 8'h00);
        end

        // Multiple switches, then drop one back to a single switch
        sif.sw_raw = 4'b0110;
        ticks(5);
        check("multi_e4.sw_clean", {4'd0, sif.sw_clean}, 8'h00);
        tick();
        check_outputs("multi_e5", 4'b0110, 1'b0, 1'b1, 3'd7);
        sif.sw_raw = 4'b0100;
        ticks(5);
        check_outputs("single_e4", 4'b0110, 1'b0, 1'b1, 3'd7);
        tick();
        check_outputs("single_e5", 4'b0100, 1'b0, 1'b0, 3'd3);
        sif.sw_raw = 4'b0000;
        ticks(8);
        check_outputs("idle_again", 4'b0000, 1'b0, 1'b0, 3'd0);

        // Reset at edge 3 of a pending change restarts debounce from scratch
        sif.sw_raw = 4'b1000;
        ticks(3);               // edges 0..2
        reset = 1'b1;
        tick();                 // edge 3
        reset = 1'b0;
        for (int k = 4; k <= 8; k++) begin
            tick();
            check($sformatf("rst_mid_e%0d.sw_clean", k), {4'd0, sif.sw_clean}, 8'h00);
        end
        tick();                 // edge 9
        check_outputs("rst_mid_e9", 4'b1000, 1'b0, 1'b0, 3'd4);

        // Key held through reset is treated as a new press
        sif.key_raw = 1'b0;
        ticks(10);
        check("held_pre.step", {7'd0, sif.step}, 8'h00);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("held_rst.step", {7'd0, sif.step}, 8'h00);
        ticks(5);
        check("held_e5m.step", {7'd0, sif.step}, 8'h00);
        tick();
        check("held_e6.step", {7'd0, sif.step}, 8'h01);
        tick();
        check("held_e7.step", {7'd0, sif.step}, 8'h00);
        sif.key_raw = 1'b1;
        ticks(8);
        check("held_release.step", {7'd0, sif.step}, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
